// File: rtl/rep_seq_checker.sv
// Multi-channel checker for a |=> b[=N] ##1 c (MODE 0) or a |=> b[->N] ##1 c (MODE 1)
// with an optional per-attempt timeout, result pulses, fail cause and saturating counters.
module rep_seq_checker #(
    parameter int CH       = 1,
    parameter int REP_N    = 3,
    parameter int MODE     = 0,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CH-1:0]       a,
    input  logic [CH-1:0]       b,
    input  logic [CH-1:0]       c,
    output logic [CH-1:0]       pass,
    output logic [CH-1:0]       fail,
    output logic [2*CH-1:0]     fail_cause,
    output logic [CH-1:0]       busy,
    output logic [CH-1:0]       drop,
    output logic [CH*CNT_W-1:0] pass_cnt,
    output logic [CH*CNT_W-1:0] fail_cnt
);

    localparam int CNT_BITS = $clog2(REP_N + 1);
    // A disabled timeout still needs a legal (1-bit) timer vector; it is simply never advanced.
    localparam int TMR_BITS = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_WAIT_C = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_EXTRA_B = 2'b01,
        CAUSE_NO_C    = 2'b10,
        CAUSE_TIMEOUT = 2'b11
    } cause_e;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        state_e               state_q, state_d;
        cause_e               cause_q, cause_d, hit_cause;
        logic [CNT_BITS-1:0]  cnt_q, cnt_d, cnt_inc;
        logic [TMR_BITS-1:0]  tmr_q, tmr_d, tmr_inc;
        logic                 pass_q, pass_d;
        logic                 fail_q, fail_d;
        logic                 drop_q, drop_d;
        logic                 busy_q, busy_d;
        logic                 hit_pass, hit_fail;
        logic [CNT_W-1:0]     pcnt_q, pcnt_d;
        logic [CNT_W-1:0]     fcnt_q, fcnt_d;

        always_comb begin
            // NOTE: every signal driven here gets a default first, so no path can infer a latch.
            state_d   = state_q;
            cause_d   = cause_q;
            cnt_d     = cnt_q;
            tmr_d     = tmr_q;
            pass_d    = 1'b0;
            fail_d    = 1'b0;
            drop_d    = 1'b0;
            pcnt_d    = pcnt_q;
            fcnt_d    = fcnt_q;
            hit_pass  = 1'b0;
            hit_fail  = 1'b0;
            hit_cause = CAUSE_NONE;
            cnt_inc   = cnt_q + CNT_BITS'(1);
            tmr_inc   = tmr_q + TMR_BITS'(1);

            if (!en) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                tmr_d   = '0;
            end else if (state_q == ST_IDLE) begin
                if (a[g]) begin
                    state_d = ST_COUNT;
                    cnt_d   = '0;
                    tmr_d   = '0;
                end
            end else begin
                if (state_q == ST_COUNT) begin
                    if (b[g]) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_BITS'(REP_N)) begin
                            state_d = ST_WAIT_C;
                        end
                    end
                end else if (MODE == 0) begin
                    if (c[g]) begin
                        hit_pass = 1'b1;
                    end else if (b[g]) begin
                        hit_fail  = 1'b1;
                        hit_cause = CAUSE_EXTRA_B;
                    end
                end else begin
                    if (c[g]) begin
                        hit_pass = 1'b1;
                    end else begin
                        hit_fail  = 1'b1;
                        hit_cause = CAUSE_NO_C;
                    end
                end

                // Timeout only fires on an edge that did not already decide the attempt.
                if (MAX_WAIT != 0 && !hit_pass && !hit_fail &&
                    tmr_inc == TMR_BITS'(MAX_WAIT)) begin
                    hit_fail  = 1'b1;
                    hit_cause = CAUSE_TIMEOUT;
                end

                if (hit_pass || hit_fail) begin
                    pass_d  = hit_pass;
                    fail_d  = hit_fail;
                    if (hit_fail) begin
                        cause_d = hit_cause;
                    end
                    state_d = a[g] ? ST_COUNT : ST_IDLE;
                    cnt_d   = '0;
                    tmr_d   = '0;
                end else begin
                    drop_d = a[g];
                    if (MAX_WAIT != 0) begin
                        tmr_d = tmr_inc;
                    end
                end
            end

            if (pass_d && !(&pcnt_q)) begin
                pcnt_d = pcnt_q + CNT_W'(1);
            end
            if (fail_d && !(&fcnt_q)) begin
                fcnt_d = fcnt_q + CNT_W'(1);
            end
        end

        assign busy_d = (state_d != ST_IDLE);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                cause_q <= CAUSE_NONE;
                cnt_q   <= '0;
                tmr_q   <= '0;
                pass_q  <= 1'b0;
                fail_q  <= 1'b0;
                drop_q  <= 1'b0;
                busy_q  <= 1'b0;
                pcnt_q  <= '0;
                fcnt_q  <= '0;
            end else begin
                // NOTE: non-blocking so every register samples the same pre-edge values.
                state_q <= state_d;
                cause_q <= cause_d;
                cnt_q   <= cnt_d;
                tmr_q   <= tmr_d;
                pass_q  <= pass_d;
                fail_q  <= fail_d;
                drop_q  <= drop_d;
                busy_q  <= busy_d;
                pcnt_q  <= pcnt_d;
                fcnt_q  <= fcnt_d;
            end
        end

        assign pass[g]                    = pass_q;
        assign fail[g]                    = fail_q;
        assign drop[g]                    = drop_q;
        assign busy[g]                    = busy_q;
        assign fail_cause[2*g +: 2]       = cause_q;
        assign pass_cnt[g*CNT_W +: CNT_W] = pcnt_q;
        assign fail_cnt[g*CNT_W +: CNT_W] = fcnt_q;
    end

endmodule
